// File: rtl/add_sub_main_if.sv
// Signal bundle for add_sub_main: clock, reset, operands, operation
// select and result. drive_random() loads fresh random operands and a
// random operation, with each IEEE-754 field drawn separately.
interface add_sub_main_if #(
  parameter int WIDTH     = 32,
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23
);

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             operation_select;
  logic [WIDTH-1:0] result;

  // Random {sign, exp, frac} for both operands plus a random add/sub choice
  task automatic drive_random();
    a = {1'($urandom()), EXP_BITS'($urandom()), MANT_BITS'($urandom())};
    b = {1'($urandom()), EXP_BITS'($urandom()), MANT_BITS'($urandom())};
    operation_select = 1'($urandom());
  endtask

endinterface

// File: rtl/add_sub_main.sv
// IEEE-754 adder/subtractor with a one-cycle registered result.
// Round to nearest even, full subnormal support, no flush-to-zero,
// canonical quiet NaN for invalid operations, no exception flags.
module add_sub_main #(
  parameter int WIDTH     = 32,
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             operation_select,
  output logic [WIDTH-1:0] result
);

  // Significand with hidden bit, then that plus guard/round/sticky
  localparam int SIG = MANT_BITS + 1;
  localparam int NW  = SIG + 3;
  // Exponent arithmetic width: headroom for carry-out and comparisons
  localparam int EW  = EXP_BITS + 2;
  localparam int LZW = $clog2(NW + 1);

  localparam logic [EXP_BITS-1:0] EXP_ONES   = '1;
  localparam logic [EW-1:0]       EXP_ONES_E = EW'(EXP_ONES);
  localparam logic [EW-1:0]       NW_E       = EW'(NW);
  localparam logic [WIDTH-1:0]    QNAN       =
    {1'b0, EXP_ONES, 1'b1, {(MANT_BITS-1){1'b0}}};

  typedef struct packed {
    logic                 sign;
    logic [EXP_BITS-1:0]  exp;
    logic [MANT_BITS-1:0] frac;
  } fp_t;

  // Leading-zero count of the pre-normalisation significand
  function automatic logic [LZW-1:0] lzc(input logic [NW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n     = n + LZW'(1);
      end
    end
    return n;
  endfunction

  fp_t op_a, op_b;
  logic a_nan, a_inf, a_zero;
  logic b_nan, b_inf, b_zero;

  // Subtraction is addition with b's sign flipped
  assign op_a = a;
  assign op_b = {b[WIDTH-1] ^ operation_select, b[WIDTH-2:0]};

  assign a_nan  = (op_a.exp == EXP_ONES) && (op_a.frac != '0);
  assign a_inf  = (op_a.exp == EXP_ONES) && (op_a.frac == '0);
  assign a_zero = (op_a[WIDTH-2:0] == '0);
  assign b_nan  = (op_b.exp == EXP_ONES) && (op_b.frac != '0);
  assign b_inf  = (op_b.exp == EXP_ONES) && (op_b.frac == '0);
  assign b_zero = (op_b[WIDTH-2:0] == '0);

  fp_t                 x, y;
  logic [EXP_BITS-1:0] ex, ey, d;
  logic [NW-1:0]       x_ext, y_ext, y_al, lost_mask, norm;
  logic [NW:0]         sum;
  logic                eff_sub, round_up;
  logic [LZW-1:0]      lz;
  logic [EW-1:0]       shamt, e_n;
  logic [WIDTH-2:0]    rounded;
  logic [WIDTH-1:0]    next_result;

  // Align, add/subtract, normalise, round, then resolve special operands
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    x           = op_a;
    y           = op_b;
    y_al        = '0;
    norm        = '0;
    shamt       = '0;
    e_n         = '0;
    next_result = '0;

    // x is always the larger magnitude; exp/frac compare as one unsigned field
    if (op_b[WIDTH-2:0] > op_a[WIDTH-2:0]) begin
      x = op_b;
      y = op_a;
    end

    // Subnormals use effective exponent 1 and hidden bit 0
    ex    = (x.exp == '0) ? EXP_BITS'(1) : x.exp;
    ey    = (y.exp == '0) ? EXP_BITS'(1) : y.exp;
    d     = ex - ey;
    x_ext = {x.exp != '0, x.frac, 3'b000};
    y_ext = {y.exp != '0, y.frac, 3'b000};

    // Right-shift the smaller significand, folding lost bits into sticky
    lost_mask = ~({NW{1'b1}} << d);
    if (EW'(d) >= NW_E) begin
      y_al = NW'(1);
    end else begin
      y_al    = y_ext >> d;
      y_al[0] = y_al[0] | (|(y_ext & lost_mask));
    end

    eff_sub = x.sign ^ y.sign;
    sum     = eff_sub ? ({1'b0, x_ext} - {1'b0, y_al})
                      : ({1'b0, x_ext} + {1'b0, y_al});
    lz      = lzc(sum[NW-1:0]);

    // Carry-out: shift right one keeping sticky. Otherwise shift left by the
    // leading-zero count, but never below effective exponent 1 (subnormal).
    if (sum[NW]) begin
      norm = {sum[NW:2], sum[1] | sum[0]};
      e_n  = EW'(ex) + EW'(1);
    end else begin
      shamt = (EW'(lz) < EW'(ex)) ? EW'(lz) : EW'(ex) - EW'(1);
      norm  = sum[NW-1:0] << shamt;
      e_n   = norm[NW-1] ? EW'(ex) - shamt : '0;
    end

    // Round to nearest even; adding into {exp, frac} lets a mantissa carry
    // bump the exponent, promote a subnormal, or reach infinity naturally.
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {e_n[EXP_BITS-1:0], norm[NW-2:3]} + (WIDTH-1)'(round_up);

    if (a_nan || b_nan)
      next_result = QNAN;
    else if (a_inf && b_inf)
      next_result = eff_sub ? QNAN : {op_a.sign, EXP_ONES, {MANT_BITS{1'b0}}};
    else if (a_inf)
      next_result = {op_a.sign, EXP_ONES, {MANT_BITS{1'b0}}};
    else if (b_inf)
      next_result = {op_b.sign, EXP_ONES, {MANT_BITS{1'b0}}};
    else if (a_zero && b_zero)
      next_result = {op_a.sign & op_b.sign, {(WIDTH-1){1'b0}}};
    else if (a_zero)
      next_result = op_b;
    else if (b_zero)
      next_result = op_a;
    else if (eff_sub && (sum == '0))
      next_result = '0;
    else if (e_n >= EXP_ONES_E)
      next_result = {x.sign, EXP_ONES, {MANT_BITS{1'b0}}};
    else
      next_result = {x.sign, rounded};
  end

  // Result register: cleared asynchronously, loads every edge otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking '<=' so every flop samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) result <= '0;
    else        result <= next_result;
  end

endmodule

// File: tb/tb_add_sub_main.sv
// Self-checking bench for add_sub_main (single precision). Stimulus pushes
// expected results into a scoreboard queue; a monitor pops and compares one
// cycle later. Expected values for random vectors come from an exact-sum
// model: operands become wide integers in units of 2^-149, are added
// exactly, and the sum is rounded to nearest even.
module tb_add_sub_main;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] expect_v;
  } sb_item_t;

  add_sub_main_if #(.WIDTH(32), .EXP_BITS(8), .MANT_BITS(23)) bus ();

  add_sub_main #(.WIDTH(32), .EXP_BITS(8), .MANT_BITS(23)) dut (
    .clk             (bus.clk),
    .rst_n           (bus.rst_n),
    .a               (bus.a),
    .b               (bus.b),
    .operation_select(bus.operation_select),
    .result          (bus.result)
  );

  sb_item_t sb_q[$];
  sb_item_t mon_item;
  int       n_checks = 0;
  int       n_pass   = 0;

  initial bus.clk = 1'b0;
  always #5 bus.clk = ~bus.clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Exact value of a finite float as an integer multiple of 2^-149
  function automatic logic signed [299:0] fp_value(input logic [31:0] x,
                                                   input logic neg);
    logic [299:0] m;
    int           e;
    m = 300'({x[30:23] != 8'd0, x[22:0]});
    e = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    m = m << (e - 1);
    return neg ? -$signed(m) : $signed(m);
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic op);
    logic                sx, sy, sr, ru;
    logic                x_nan, y_nan, x_inf, y_inf;
    logic signed [299:0] total;
    logic [299:0]        mag, one, mask, rem, half;
    logic [23:0]         mant;
    logic [30:0]         body;
    int                  msb, shift, expf;
    sx    = x[31];
    sy    = y[31] ^ op;
    x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    if (x_nan || y_nan) return 32'h7FC0_0000;
    if (x_inf && y_inf) return (sx == sy) ? {sx, 8'hFF, 23'd0} : 32'h7FC0_0000;
    if (x_inf) return {sx, 8'hFF, 23'd0};
    if (y_inf) return {sy, 8'hFF, 23'd0};

    total = fp_value(x, sx) + fp_value(y, sy);
    if (total == 0) return {sx & sy, 31'd0};
    sr  = total[299];
    mag = sr ? 300'(-total) : 300'(total);
    msb = -1;
    for (int i = 299; i >= 0; i--) if (mag[i] && msb < 0) msb = i;
    // Below 2^24 units the integer is itself the {exp, frac} encoding
    if (msb <= 23) return {sr, mag[30:0]};

    shift = msb - 23;
    one   = 300'(1);
    mant  = 24'(mag >> shift);
    mask  = (one << shift) - one;
    rem   = mag & mask;
    half  = one << (shift - 1);
    ru    = (rem > half) || ((rem == half) && mant[0]);
    expf  = shift + 1;
    if (expf >= 255) return {sr, 8'hFF, 23'd0};
    body = {8'(expf), mant[22:0]} + 31'(ru);
    return {sr, body};
  endfunction

  // Biased operand mix: zeros, infinities, NaNs, subnormals, extremes
  function automatic logic [31:0] rand_fp();
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = 1'($urandom());
    f = 23'($urandom());
    case ($urandom_range(0, 15))
      0:       begin e = 8'd0;  f = 23'd0; end
      1:       begin e = 8'hFF; f = 23'd0; end
      2:       begin e = 8'hFF; f = f | 23'd1; end
      3, 4:    e = 8'd0;
      5:       e = 8'($urandom_range(1, 3));
      6:       e = 8'($urandom_range(250, 254));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {s, e, f};
  endfunction

  // Second operand often close to the first to provoke cancellation
  function automatic logic [31:0] rand_partner(input logic [31:0] x);
    logic [22:0] flip;
    int          e;
    case ($urandom_range(0, 3))
      0: return rand_fp();
      1: begin
        e = int'(x[30:23]) + int'($urandom_range(0, 6)) - 3;
        if (e < 0)   e = 0;
        if (e > 254) e = 254;
        return {1'($urandom()), 8'(e), 23'($urandom())};
      end
      2: begin
        flip = 23'(1) << $urandom_range(0, 22);
        return {1'($urandom()), x[30:23], x[22:0] ^ flip};
      end
      default: return {1'($urandom()), x[30:0]};
    endcase
  endfunction

  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic op, input logic [31:0] exp_v);
    @(negedge bus.clk);
    bus.a                = av;
    bus.b                = bv;
    bus.operation_select = op;
    sb_q.push_back('{a: av, b: bv, op: op, expect_v: exp_v});
  endtask

  task automatic issue_random();
    logic [31:0] av;
    @(negedge bus.clk);
    if ($urandom_range(0, 7) == 0) begin
      bus.drive_random();
    end else begin
      av                   = rand_fp();
      bus.a                = av;
      bus.b                = rand_partner(av);
      bus.operation_select = 1'($urandom());
    end
    sb_q.push_back('{a: bus.a, b: bus.b, op: bus.operation_select,
                     expect_v: ref_add(bus.a, bus.b, bus.operation_select)});
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 50) begin
      @(posedge bus.clk);
      budget++;
    end
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: result is valid one edge after each issued vector
  always @(posedge bus.clk) begin
    #1;
    if (bus.rst_n && sb_q.size() != 0) begin
      mon_item = sb_q.pop_front();
      check($sformatf("a=%h b=%h op=%0d", mon_item.a, mon_item.b, mon_item.op),
            bus.result, mon_item.expect_v);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected self-termination");
    $fatal(1);
  end

  initial begin
    bus.rst_n            = 1'b0;
    bus.a                = 32'd0;
    bus.b                = 32'd0;
    bus.operation_select = 1'b0;
    repeat (2) @(posedge bus.clk);
    #1 check("reset_state", bus.result, 32'd0);
    @(negedge bus.clk);
    bus.rst_n = 1'b1;

    issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
    issue(32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000);
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000);
    issue(32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000);
    issue(32'h4049_0FDB, 32'h8000_0000, 1'b1, 32'h4049_0FDB);
    issue(32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000);
    issue(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000);
    issue(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002);
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);
    issue(32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b0, 32'hFF80_0000);
    issue(32'h7F7F_FFFF, 32'h7300_0000, 1'b0, 32'h7F80_0000);
    issue(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000);
    issue(32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000);
    issue(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000);
    issue(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002);
    issue(32'h0080_0000, 32'h0000_0001, 1'b1, 32'h007F_FFFF);

    for (int i = 0; i < 1000; i++) issue_random();

    issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
    drain();

    // Asynchronous clear mid-cycle, then hold while inputs keep changing
    @(negedge bus.clk);
    check("pre_reset_result", bus.result, 32'h4040_0000);
    #2 bus.rst_n = 1'b0;
    #1 check("async_reset_clear", bus.result, 32'd0);
    bus.a = 32'h3F80_0000;
    bus.b = 32'h3F80_0000;
    bus.operation_select = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge bus.clk);
      #1 check("reset_hold", bus.result, 32'd0);
    end

    // First edge after release registers the inputs present at release
    @(negedge bus.clk);
    bus.a                = 32'h4000_0000;
    bus.b                = 32'h3F80_0000;
    bus.operation_select = 1'b1;
    sb_q.push_back('{a: 32'h4000_0000, b: 32'h3F80_0000, op: 1'b1,
                     expect_v: 32'h3F80_0000});
    bus.rst_n = 1'b1;

    for (int i = 0; i < 1000; i++) issue_random();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
